logic_vector_sequencer: RTL
===========================

// Module: logic_vector_sequencer
// PURPOSE
//  Upstream stimulus stage for the 6-input combinational logic block. Drives its A..F inputs from a
//  generated vector sequence and samples its single output after a settle window. Compacts all responses
//  into a ones-count and a 16-bit MISR signature, so a run is checked against one golden value.
// PARAMETERS
//  WIDTH        6   vector width; bit5..bit0 = A..F
//  HOLD_CYCLES  5   settle cycles per vector before sampling; legal range >=1
//  CNT_W        8   width of ones_count and vec_index
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  start       in   1      start a run; honoured only in IDLE
//  abort       in   1      stop the run and return to IDLE
//  mode        in   2      00 count-up; 01 walking-one; 10 LFSR; 11 same as 00
//  seed        in   WIDTH  first vector for modes 00 and 10; ignored in mode 01
//  dut_out     in   1      output of the combinational block
//  vec         out  WIDTH  vector applied to the block {A,B,C,D,E,F}
//  vec_valid   out  1      high while vec is driven by an active run
//  sample      out  1      1-cycle pulse; dut_out is captured at the end of this cycle
//  busy        out  1      high in APPLY and SAMPLE
//  done        out  1      set when a run completes; cleared when the next start is accepted
//  ones_count  out  CNT_W  number of sampled dut_out==1; saturates at all-ones
//  vec_index   out  CNT_W  number of vectors sampled in the current or last run
//  signature   out  16     MISR of sampled responses
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE. Reset mid-run: immediate return to IDLE; done stays 0.
//  FSM IDLE->APPLY: on start&!abort. Latch mode and seed; clear ones_count, vec_index, signature and done.
//   Next cycle: vec = first vector, vec_valid = 1.
//  APPLY: holds vec stable for HOLD_CYCLES cycles, then goes to SAMPLE.
//  SAMPLE: lasts 1 cycle with sample=1 and vec unchanged. At the clock edge:
//   - vec_index increments.
//   - ones_count increments if dut_out=1.
//   - signature updates.
//   Then go to APPLY with the next vector, or to IDLE with done=1 if this was the last vector.
//   Each vector takes HOLD_CYCLES+1 cycles.
//  First vector / next vector / last vector, per mode:
//   00: seed / vec+1 / vec == all-ones; 2^WIDTH - seed vectors.
//   01: 1 / vec<<1 / vec == 1<<(WIDTH-1); WIDTH vectors.
//   10: seed, or 1 if seed==0 / {vec[4:0], vec[5]^vec[4]} (x^6+x^5+1) / after 2^WIDTH-1 vectors; vec never 0.
//  MISR: fb = s[15]^s[13]^s[12]^s[10]; s_next = {s[14:0], fb^dut_out}.
//  abort in APPLY or SAMPLE: IDLE next cycle; vec_valid=0; done not set; counters keep their values.
//   If abort coincides with the sample edge, that sample is discarded.
//  start while busy: ignored. start&abort in IDLE: abort wins, nothing starts.
//  After the run: vec_valid=0 in IDLE; vec holds its last value.
//  Widths: vec_index never wraps for WIDTH=6, CNT_W=8; a 64-vector run gives vec_index=64.
// STRUCTURE
//  Package lvs_pkg:
//   - state typedef {IDLE, APPLY, SAMPLE}
//   - mode constants MODE_COUNT, MODE_WALK, MODE_LFSR
//   - MISR tap constant 16'hB400
//  Sub-module misr16: clk, reset, clr, en, din, sig[15:0]. The FSM, the vector generator and the hold
//  counter live in the top module.
// TESTING
//  1. mode=00, seed=0, dut_out=&vec, HOLD=5 -> 64 vectors, done after 1+64*6 cycles;
//     ones_count=1, vec_index=64.
//  2. mode=01, dut_out=vec[0] -> vec 01,02,04,08,10,20; ones_count=1, vec_index=6.
//  3. mode=10, seed=0 -> first vec=1; 63 distinct non-zero vectors; done with vec_index=63.
//  4. dut_out tied 0, any mode -> signature=16'h0000. dut_out tied 1, mode 01 -> signature equals the
//     bench model after 6 shifts.
//  5. start pulsed mid-run -> ignored, the sequence is unchanged. abort at vector 3 -> IDLE, done=0,
//     vec_index=2.
//  6. reset asserted asynchronously in SAMPLE -> all outputs 0 before the next edge; a new start runs
//     cleanly. HOLD_CYCLES=1 -> 2 cycles per vector.

Source files
------------

// File: rtl/lvs_pkg.sv
// Shared types and constants for the logic vector sequencer.
// State encoding, mode codes and the MISR feedback taps.
package lvs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE
    } state_e;

    localparam logic [1:0] MODE_COUNT = 2'b00;
    localparam logic [1:0] MODE_WALK  = 2'b01;
    localparam logic [1:0] MODE_LFSR  = 2'b10;

    localparam logic [15:0] MISR_TAPS = 16'hB400;

    function automatic logic misr_fb(input logic [15:0] s);
        return ^(s & MISR_TAPS);
    endfunction

endpackage

// File: rtl/logic_vector_sequencer_if.sv
// Bus between the sequencer and its driver/consumer.
// master drives run control and the block response; slave is the sequencer.
interface logic_vector_sequencer_if #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [1:0]       mode;
    logic [WIDTH-1:0] seed;
    logic             dut_out;
    logic [WIDTH-1:0] vec;
    logic             vec_valid;
    logic             sample;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ones_count;
    logic [CNT_W-1:0] vec_index;
    logic [15:0]      signature;

    modport master (
        output start, abort, mode, seed, dut_out,
        input  vec, vec_valid, sample, busy, done,
        input  ones_count, vec_index, signature
    );

    modport slave (
        input  start, abort, mode, seed, dut_out,
        output vec, vec_valid, sample, busy, done,
        output ones_count, vec_index, signature
    );
endinterface

// File: rtl/logic_vector_sequencer_misr16.sv
// 16-bit multiple-input signature register with one serial input.
// clr has priority over en so a new run always starts from zero.
module misr16
    import lvs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    logic [15:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[14:0], misr_fb(sig_q) ^ din};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/logic_vector_sequencer.sv
// Vector sequencer: applies generated vectors to a combinational block,
// samples its output after a settle window and compacts the responses.
module logic_vector_sequencer
    import lvs_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int HOLD_CYCLES = 5,
    parameter int CNT_W       = 8
) (
    input logic clk,
    input logic reset,
    logic_vector_sequencer_if.slave bus
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LFSR_LAST = CNT_W'((1 << WIDTH) - 2);
    localparam logic [WIDTH-1:0] VEC_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] WALK_LAST = VEC_ONE << (WIDTH - 1);

    state_e           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             misr_clr;
    logic             misr_en;
    logic [15:0]      sig;

    function automatic logic [WIDTH-1:0] first_vec(
        input logic [1:0]       m,
        input logic [WIDTH-1:0] s
    );
        unique case (m)
            MODE_WALK: return VEC_ONE;
            MODE_LFSR: return (s == '0) ? VEC_ONE : s;
            default:   return s;
        endcase
    endfunction

    // LFSR taps implement x^6+x^5+1 for the default width
    function automatic logic [WIDTH-1:0] next_vec(
        input logic [1:0]       m,
        input logic [WIDTH-1:0] v
    );
        unique case (m)
            MODE_WALK: return v << 1;
            MODE_LFSR: return {v[WIDTH-2:0], v[WIDTH-1] ^ v[WIDTH-2]};
            default:   return v + VEC_ONE;
        endcase
    endfunction

    function automatic logic last_vec(
        input logic [1:0]       m,
        input logic [WIDTH-1:0] v,
        input logic [CNT_W-1:0] n
    );
        unique case (m)
            MODE_WALK: return v == WALK_LAST;
            MODE_LFSR: return n == LFSR_LAST;
            default:   return &v;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        vec_d    = vec_q;
        mode_d   = mode_q;
        ones_d   = ones_q;
        idx_d    = idx_q;
        done_d   = done_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d  = APPLY;
                    mode_d   = bus.mode;
                    vec_d    = first_vec(bus.mode, bus.seed);
                    hold_d   = '0;
                    ones_d   = '0;
                    idx_d    = '0;
                    done_d   = 1'b0;
                    misr_clr = 1'b1;
                end
            end
            APPLY: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            SAMPLE: begin
                // an abort on the sample edge discards that response
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    misr_en = 1'b1;
                    idx_d   = idx_q + CNT_W'(1);
                    if (bus.dut_out && !(&ones_q)) begin
                        ones_d = ones_q + CNT_W'(1);
                    end
                    if (last_vec(mode_q, vec_q, idx_q)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = APPLY;
                        vec_d   = next_vec(mode_q, vec_q);
                        hold_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            vec_q   <= '0;
            mode_q  <= MODE_COUNT;
            ones_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
            mode_q  <= mode_d;
            ones_q  <= ones_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    misr16 u_misr (
        .clk   (clk),
        .reset (reset),
        .clr   (misr_clr),
        .en    (misr_en),
        .din   (bus.dut_out),
        .sig   (sig)
    );

    assign bus.vec        = vec_q;
    assign bus.vec_valid  = (state_q != IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.sample     = (state_q == SAMPLE);
    assign bus.done       = done_q;
    assign bus.ones_count = ones_q;
    assign bus.vec_index  = idx_q;
    assign bus.signature  = sig;

endmodule
